fetch_ctrl: RTL

- Sequencer for the program counter and instruction fetch path of the multi-cycle RV32I core.
- Owns the PC register and drives the instruction-memory request/acknowledge handshake.
- Selects the next PC with priority trap > redirect (branch/jump target from the ALU) > sequential pc+4.
- Holds each fetched instruction until decode accepts it, and discards in-flight fetches made stale by a redirect.

---
 rtl/fetch_ctrl.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: PC sequencer and instruction-fetch handshake for the multi-cycle RV32I core.
// Optional fetch watchdog enabled by defining FETCH_TIMEOUT_EN.
`default_nettype none

module fetch_ctrl #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC       = 32'h0000_0100,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        trap,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_4,
  input  logic        id_ready,
  output logic        misalign_err,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t      state, state_d;
  logic [31:0] pc, pc_d;
  logic [31:0] drain_addr;
  logic        capture, drain_load, misalign_d;
  logic        redir, ack_eff;
  logic [31:0] new_pc;
  logic        timeout_hit;
  logic        bus_err_q;

  assign redir   = redirect_valid | trap;
  assign new_pc  = trap ? TRAP_VEC : {redirect_target[31:2], 2'b00};
  assign ack_eff = imem_ack & imem_req;

  assign if_valid     = (state == VALID);
  assign imem_addr    = (state == DRAIN) ? drain_addr : pc;
  assign bus_err      = bus_err_q;

`ifdef FETCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;

  // Request is withheld for the single cycle that bus_err is pulsing.
  assign imem_req = ((state == FETCH) || (state == DRAIN)) && !bus_err_q;
  assign timeout_hit = imem_req && !imem_ack && (cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      bus_err_q <= 1'b0;
    end else begin
      bus_err_q <= timeout_hit;
      if (imem_req && !ack_eff && (state_d == state) && !timeout_hit)
        cnt <= cnt + 1'b1;
      else
        cnt <= '0;
    end
  end
`else
  assign imem_req    = (state == FETCH) || (state == DRAIN);
  assign timeout_hit = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) bus_err_q <= 1'b0;
    else     bus_err_q <= 1'b0;
  end
`endif

  always_comb begin
    state_d    = state;
    pc_d       = pc;
    capture    = 1'b0;
    drain_load = 1'b0;
    misalign_d = 1'b0;

    if (state != IDLE)
      misalign_d = redirect_valid && !trap && (redirect_target[1:0] != 2'b00);

    case (state)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (redir) begin
          pc_d = new_pc;
          // Only an outstanding, unanswered request needs draining.
          if (imem_req && !ack_eff) begin
            state_d    = DRAIN;
            drain_load = 1'b1;
          end
        end else if (ack_eff) begin
          capture = 1'b1;
          pc_d    = pc + 32'd4;
          state_d = VALID;
        end
      end
      VALID: begin
        if (redir) begin
          pc_d    = new_pc;
          state_d = FETCH;
        end else if (id_ready) begin
          state_d = FETCH;
        end
      end
      DRAIN: begin
        if (redir) pc_d = new_pc;
        if (ack_eff) state_d = FETCH;
      end
      default: state_d = IDLE;
    endcase

    if (timeout_hit) begin
      pc_d       = TRAP_VEC;
      state_d    = FETCH;
      drain_load = 1'b0;
      capture    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc           <= RESET_PC;
      drain_addr   <= RESET_PC;
      if_instr     <= NOP;
      if_pc        <= 32'h0000_0000;
      if_pc_4      <= 32'h0000_0004;
      misalign_err <= 1'b0;
    end else begin
      pc           <= pc_d;
      misalign_err <= misalign_d;
      if (drain_load) drain_addr <= pc;
      if (capture) begin
        if_instr <= imem_rdata;
        if_pc    <= pc;
        if_pc_4  <= pc + 32'd4;
      end
    end
  end

endmodule

`default_nettype wire
